dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the RV32I core's load/store path and the test/debug access port.
- Sequences each access through a fixed-latency memory and returns read data to the winning requester.
- Holds the core stalled while its access, or a competing debug access, is in flight.
- Sits between the datapath's load/store unit and the data memory instance.

Parameters:
ADDR_W, 8, byte-address width of the data memory.
DATA_W, 32, data width; fixed at 32 for RV32I.
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range is 1 to 15.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
core_req  in  1  core access request; held until core_done
core_we  in  1  1 = store, 0 = load
core_size  in  3  Read/WriteControl code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  store data
core_stall  out  1  equals core_req & ~core_done (combinational)
core_done  out  1  one-cycle completion pulse
core_err  out  1  misalignment flag, valid with core_done
core_rdata  out  DATA_W  registered load data
dbg_req, dbg_we  in  1 each  debug request and write enable; access size is always word (010)
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_done, dbg_err  out  1 each  as the core equivalents
dbg_rdata  out  DATA_W  registered debug read data
mem_en, mem_we  out  1 each  memory strobe and write enable
mem_size  out  3  size code passed to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  FSM not in IDLE

Behaviour:
- The interface is one clock (clk) with a synchronous active-low reset (rst).
- Reset (rst = 0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0, including both rdata registers and busy.
  - last_gnt is set to DBG, so the first tie goes to the core.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any request is present, pick a winner and latch its we, size, addr and wdata into internal registers.
  - Requesters must keep their request fields stable until their done pulse.
- Alignment check (in IDLE):
  - Half-word with addr[0] = 1 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - A misaligned request goes directly to DONE with err = 1; no mem_en is issued and rdata is unchanged.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle with mem_en = 1; mem_* carry the latched values. Go to WAIT.
- WAIT:
  - A counter counts MEM_LAT cycles.
  - In the last WAIT cycle, capture mem_rdata into the winner's rdata register (loads only). Go to DONE.
- DONE:
  - Winner's done = 1 for exactly one cycle; err = 0 unless misaligned.
  - Update last_gnt to the winner. Go to IDLE.
- Latency:
  - Aligned access, req to done: MEM_LAT + 2 cycles (MEM_LAT = 1 gives 3).
  - Misaligned access: 1 cycle.
- Stores leave rdata unchanged.
- Both requests high in IDLE: winner is decided by the arbitration policy (see Optional Feature).
- The loser is not dropped; it waits in IDLE and is served in the next round.
- A req still high in the IDLE cycle after done is treated as a new request; requesters must deassert after done.
- Whenever the FSM is not in IDLE, mem_en is 0 except in ISSUE.
- The memory-side outputs are held (not zeroed) outside ISSUE.
- Reset mid-operation:
  - The access is abandoned with no done pulse.
  - mem_en is 0 from the next cycle.
  - rdata registers are cleared.
- A debug write to an address the core later reads is ordered purely by grant order; there is no forwarding.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A tie goes to the requester opposite last_gnt.
- Undefined: fixed priority, core always wins ties. last_gnt is still maintained but unused. Debug may starve; this is acceptable for the test flow.

Decomposition:
- Package dmem_arb_pkg holds:
  - size codes SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU;
  - state enum IDLE, ISSUE, WAIT, DONE;
  - grant id type GNT_CORE, GNT_DBG.
- Sub-module dmem_align_chk: combinational; inputs size and addr[1:0], output misaligned flag. Instantiated once, on the IDLE winner's fields.

Test Plan:
- MEM_LAT = 1: core load word at 0x10 with memory returning 0xDEADBEEF -> mem_en in cycle 1, core_done in cycle 3, core_rdata = 0xDEADBEEF, core_stall high in cycles 0–2.
- core_req and dbg_req rise together twice, with the RR macro defined -> grant order core, dbg, core; without the macro -> core, core.
- Core half load at 0x11 -> no mem_en, core_done and core_err in the next cycle, core_rdata unchanged.
- MEM_LAT = 3: debug write of 0x12345678 to 0x20 -> mem_we = 1 and mem_size = 010 in cycle 1, dbg_done in cycle 5, dbg_rdata unchanged.
- rst driven low during WAIT -> next cycle busy = 0, no done pulse, both rdata = 0; a new core request afterwards completes normally.
- Debug access in flight when core_req rises -> core_stall stays high until the debug access's DONE, then the core access is issued and core_done follows MEM_LAT + 2 cycles after IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared size codes, FSM states and grant ids for the data-memory arbiter.
package dmem_arb_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {GNT_CORE, GNT_DBG} gnt_e;
endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: flags half-words on odd addresses and words off a 4-byte boundary.
module dmem_align_chk
  import dmem_arb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic       misaligned_o
);
  assign misaligned_o = ((size_i == SZ_H || size_i == SZ_HU) && addr_i[0]) ||
                        (size_i == SZ_W && addr_i != 2'b00);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the core load/store path and the debug port.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise the core always wins a tie.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_size,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d, last_gnt_q, last_gnt_d;
  logic              we_q, we_d, err_q, err_d, tie_dbg, win_dbg, mis;
  logic [2:0]        size_q, size_d, sel_size;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, core_rdata_q, core_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic [3:0]        cnt_q, cnt_d;
`ifdef DMEM_ARB_RR_EN
  assign tie_dbg = last_gnt_q == GNT_CORE;
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_q;
  assign tie_dbg = 1'b0;
`endif
  assign win_dbg  = dbg_req & (~core_req | tie_dbg);
  assign sel_size = win_dbg ? SZ_W : core_size;
  assign sel_addr = win_dbg ? dbg_addr : core_addr;
  dmem_align_chk u_align (
    .size_i      (sel_size),
    .addr_i      (sel_addr[1:0]),
    .misaligned_o(mis)
  );
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      IDLE: if (core_req || dbg_req) begin
        gnt_d   = win_dbg ? GNT_DBG : GNT_CORE;
        we_d    = win_dbg ? dbg_we : core_we;
        size_d  = sel_size;
        addr_d  = sel_addr;
        wdata_d = win_dbg ? dbg_wdata : core_wdata;
        err_d   = mis;
        state_d = mis ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == LAST) begin
        core_rdata_d = (!we_q && gnt_q == GNT_CORE) ? mem_rdata : core_rdata_q;
        dbg_rdata_d  = (!we_q && gnt_q == GNT_DBG) ? mem_rdata : dbg_rdata_q;
        state_d      = DONE;
      end else cnt_d = cnt_q + 4'd1;
      DONE: begin
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_CORE;
      last_gnt_q   <= GNT_DBG;
      we_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end
  assign core_done  = state_q == DONE && gnt_q == GNT_CORE;
  assign dbg_done   = state_q == DONE && gnt_q == GNT_DBG;
  assign core_err   = core_done & err_q;
  assign dbg_err    = dbg_done & err_q;
  assign core_stall = core_req & ~core_done;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_en     = state_q == ISSUE;
  assign mem_we     = we_q;
  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter at MEM_LAT 1 and 3.
module tb_dmem_arbiter;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  logic clk = 1'b0;
  logic rst;
  logic core_req, core_we, core_stall, core_done, core_err;
  logic [2:0] core_size;
  logic [7:0] core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic dbg_req, dbg_we, dbg_done, dbg_err;
  logic [7:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic mem_en, mem_we, busy;
  logic [2:0] mem_size;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic c3_req, c3_we, c3_stall, c3_done, c3_err;
  logic [2:0] c3_size;
  logic [7:0] c3_addr;
  logic [31:0] c3_wdata, c3_rdata;
  logic dbg_req3, dbg_we3, dbg_done3, dbg_err3;
  logic [7:0] dbg_addr3;
  logic [31:0] dbg_wdata3, dbg_rdata3;
  logic mem_en3, mem_we3, busy3;
  logic [2:0] mem_size3;
  logic [7:0] mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;
  logic [31:0] mem [256];
  logic [15:0] en_sr = '0, en_sr3 = '0;
  logic [7:0] ra = '0, ra3 = '0;
  int checks = 0, failures = 0;
  bit last_w;
  logic [31:0] exp_core, exp_dbg, exp_dbg3;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT1)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_size(core_size), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_done(core_done),
    .core_err(core_err), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst),
    .core_req(c3_req), .core_we(c3_we), .core_size(c3_size), .core_addr(c3_addr),
    .core_wdata(c3_wdata), .core_stall(c3_stall), .core_done(c3_done),
    .core_err(c3_err), .core_rdata(c3_rdata),
    .dbg_req(dbg_req3), .dbg_we(dbg_we3), .dbg_addr(dbg_addr3), .dbg_wdata(dbg_wdata3),
    .dbg_done(dbg_done3), .dbg_err(dbg_err3), .dbg_rdata(dbg_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_size(mem_size3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory model: data is valid only in the single cycle MEM_LAT after the strobe.
  always @(posedge clk) begin
    en_sr  <= {en_sr[14:0], mem_en};
    en_sr3 <= {en_sr3[14:0], mem_en3};
    if (mem_en) ra <= mem_addr;
    if (mem_en3) ra3 <= mem_addr3;
  end
  assign mem_rdata  = en_sr[LAT1-1] ? mem[ra] : 32'hBAD0_BAD0;
  assign mem_rdata3 = en_sr3[LAT3-1] ? mem[ra3] : 32'hBAD3_BAD3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [2:0] sz, input logic [7:0] a);
    int al;
    al = (sz == 3'b001 || sz == 3'b101) ? 2 : (sz == 3'b010) ? 4 : 1;
    return (int'(a) % al) != 0;
  endfunction

  function automatic bit tie_to_dbg();
`ifdef DMEM_ARB_RR_EN
    return last_w == 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One round: optional core and debug access; core may rise cdel cycles late.
  task automatic run(input bit cr, input int cdel, input bit cwe, input logic [2:0] csz,
                     input logic [7:0] ca, input logic [31:0] cwd,
                     input bit dr, input bit dwe, input logic [7:0] da, input logic [31:0] dwd);
    bit cm, dm, dfirst, gce, gde;
    int cl, dl, ct, dt, ci, di, gct, gdt, mb, sb, c;
    logic [31:0] gcr, gdr;
    cm = misal(csz, ca);
    dm = misal(3'b010, da);
    cl = cm ? 1 : LAT1 + 2;
    dl = dm ? 1 : LAT1 + 2;
    dfirst = dr && (!cr || cdel > 0 || tie_to_dbg());
    if (dfirst) begin
      dt = dl; ct = dl + 1 + cl; di = dm ? -1 : 1; ci = cm ? -1 : dl + 2;
    end else begin
      ct = cl; dt = cl + 1 + dl; ci = cm ? -1 : 1; di = dm ? -1 : cl + 2;
    end
    if (!cr) begin ct = -1; ci = -1; end
    if (!dr) begin dt = -1; di = -1; end
    if (cr && !cm && !cwe) exp_core = mem[ca];
    if (dr && !dm && !dwe) exp_dbg = mem[da];
    @(negedge clk);
    core_req = cr && cdel == 0; core_we = cwe; core_size = csz; core_addr = ca; core_wdata = cwd;
    dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    gct = -1; gdt = -1; mb = 0; sb = 0; c = 0;
    gce = 1'bx; gde = 1'bx; gcr = 'x; gdr = 'x;
    while (c < 40 && ((cr && gct < 0) || (dr && gdt < 0))) begin
      if (c > 0) @(negedge clk);
      if (cr && c == cdel) core_req = 1'b1;
      #1;
      if (core_stall !== (core_req && c != ct)) sb++;
      if (mem_en) begin
        if (c == ci) mb += int'(mem_we !== cwe || mem_size !== csz || mem_addr !== ca || mem_wdata !== cwd);
        else if (c == di) mb += int'(mem_we !== dwe || mem_size !== 3'b010 || mem_addr !== da || mem_wdata !== dwd);
        else mb++;
      end else if (c == ci || c == di) mb++;
      if (core_done) begin gct = c; gce = core_err; gcr = core_rdata; core_req = 1'b0; end
      if (dbg_done) begin gdt = c; gde = dbg_err; gdr = dbg_rdata; dbg_req = 1'b0; end
      c++;
    end
    chk("core_done_cycle", gct, ct);
    chk("dbg_done_cycle", gdt, dt);
    chk("mem_side", mb, 0);
    chk("core_stall", sb, 0);
    if (cr) begin chk("core_err", 32'(gce), 32'(cm)); chk("core_rdata", gcr, exp_core); end
    if (dr) begin chk("dbg_err", 32'(gde), 32'(dm)); chk("dbg_rdata", gdr, exp_dbg); end
    if (cr && dr) last_w = !dfirst;
    else if (cr || dr) last_w = dr;
  endtask

  task automatic run3(input bit we, input logic [7:0] a, input logic [31:0] wd);
    int dc, mb;
    logic [31:0] rd;
    rd = 'x;
    if (!we) exp_dbg3 = mem[a];
    @(negedge clk);
    dbg_req3 = 1'b1; dbg_we3 = we; dbg_addr3 = a; dbg_wdata3 = wd;
    dc = -1; mb = 0;
    for (int c = 0; c < 30 && dc < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_en3 !== (c == 1)) mb++;
      if (c == 1) mb += int'(mem_we3 !== we || mem_size3 !== 3'b010 || mem_addr3 !== a || mem_wdata3 !== wd);
      if (dbg_done3) begin dc = c; rd = dbg_rdata3; dbg_req3 = 1'b0; end
    end
    chk("lat3_done_cycle", dc, LAT3 + 2);
    chk("lat3_mem_side", mb, 0);
    chk("lat3_dbg_rdata", rd, exp_dbg3);
  endtask

  initial begin
    bit [2:0] seq, exp_seq;
    bit w;
    int n, c3;
    logic [2:0] szs [5];
    szs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b0;
    core_req = 0; core_we = 0; core_size = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    c3_req = 0; c3_we = 0; c3_size = 0; c3_addr = 0; c3_wdata = 0;
    dbg_req3 = 0; dbg_we3 = 0; dbg_addr3 = 0; dbg_wdata3 = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hDEADBEEF;
    exp_core = 0; exp_dbg = 0; exp_dbg3 = 0; last_w = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_fields", {mem_we, mem_size, mem_addr, mem_wdata}, 0);
    chk("rst_dones", {core_done, dbg_done, core_err, dbg_err}, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    rst = 1'b1;
    // Both requests held high: record the first three grants.
    w = last_w; exp_seq = '0;
    for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_RR_EN
      w = ~w;
`else
      w = 1'b0;
`endif
      exp_seq[k] = w;
    end
    @(negedge clk);
    core_req = 1; core_we = 0; core_size = 3'b010; core_addr = 8'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h44;
    n = 0; seq = '0; c3 = -1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (core_done || dbg_done) begin
        seq[n] = dbg_done;
        n++;
        if (n == 3) c3 = c;
      end
    end
    core_req = 0; dbg_req = 0;
    chk("grant_order", seq, exp_seq);
    chk("grant_third_cycle", c3, 3 * (LAT1 + 2) + 2);
    exp_core = mem[8'h40];
    if (exp_seq != 3'b000) exp_dbg = mem[8'h44];
    last_w = exp_seq[2];
    run(1, 0, 0, 3'b010, 8'h10, 32'h0, 0, 0, 8'h0, 32'h0);
    chk("deadbeef", core_rdata, 32'hDEADBEEF);
    run(1, 0, 0, 3'b001, 8'h11, 32'h0, 0, 0, 8'h0, 32'h0);
    run(1, 0, 1, 3'b010, 8'h18, 32'hCAFE_F00D, 0, 0, 8'h0, 32'h0);
    run(1, 1, 0, 3'b010, 8'h50, 32'h0, 1, 0, 8'h54, 32'h0);
    // Reset while the core load sits in WAIT.
    @(negedge clk);
    core_req = 1; core_we = 0; core_size = 3'b010; core_addr = 8'h30;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_done", {core_done, dbg_done}, 0);
    chk("midrst_rdata", {core_rdata, dbg_rdata}, 64'h0);
    core_req = 0; rst = 1'b1;
    exp_core = 0; exp_dbg = 0; last_w = 1'b1;
    run(1, 0, 0, 3'b010, 8'h34, 32'h0, 0, 0, 8'h0, 32'h0);
    for (int r = 0; r < 30; r++) begin
      bit cr, dr;
      int sel;
      sel = $urandom_range(2);
      cr = sel != 1;
      dr = sel != 0;
      run(cr, (cr && dr) ? $urandom_range(1) : 0, 1'($urandom), szs[$urandom_range(4)],
          8'($urandom), $urandom, dr, 1'($urandom), 8'($urandom), $urandom);
    end
    run3(1, 8'h20, 32'h1234_5678);
    run3(0, 8'h24, 32'h0);
    run3(1, 8'h28, 32'h0BAD_CAFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
